// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 definitions: FSM states, parity helper, command bytes
// Contents:
//   ps2_tx_state_t : host transmit FSM state encoding
//   odd_parity()   : parity bit that makes the 9-bit frame payload odd
//   CMD_*          : common host-to-keyboard command bytes
//   PARITY_EDGE    : clock falling edge on which the parity bit is driven
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_STOP,
    ST_ACK,
    ST_RELEASE
  } ps2_tx_state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;

  // Edges 1..8 carry data LSB-first, edge 9 carries parity.
  localparam logic [3:0] PARITY_EDGE  = 4'd9;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// rtl/ps2_sync_edge.sv - 2-flop synchronizer with falling-edge detect for one PS/2 line
// Ports:
//   i_clk   : system clock
//   i_reset : synchronous active-high reset, flops preset to 1 (idle line)
//   i_line  : raw asynchronous line
//   o_sync  : synchronized line level
//   o_fall  : one-cycle pulse when the synchronized level goes 1 -> 0
module ps2_sync_edge (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_line,
  output logic o_sync,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Ports:
//   i_clk, i_reset  : system clock, synchronous active-high reset
//   i_tx_data       : command byte, captured when accepted
//   i_tx_valid      : send request, honoured only while o_tx_ready=1
//   o_tx_ready      : high in IDLE
//   i_ps2clk        : raw PS/2 clock line
//   i_ps2data       : raw PS/2 data line
//   o_ps2clk_low    : open-drain enable, 1 pulls PS2CLK low
//   o_ps2data_low   : open-drain enable, 1 pulls PS2Data low
//   o_busy          : high outside IDLE
//   o_done          : one-cycle pulse, device acked and both lines idle
//   o_err           : one-cycle pulse, missing ack or timeout
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int INHIBIT_US  = 100,
  parameter int TIMEOUT_MS  = 20
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  input  logic       i_ps2clk,
  input  logic       i_ps2data,
  output logic       o_ps2clk_low,
  output logic       o_ps2data_low,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam int INHIBIT_CYCLES = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
  localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1000 * TIMEOUT_MS;
  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  ps2_tx_state_t    r_state;
  ps2_tx_state_t    w_state_nxt;
  logic [INH_W-1:0] r_inh_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [3:0]       r_edge_cnt;
  logic [8:0]       r_shift;
  logic             r_data_low;

  logic w_clk_sync;
  logic w_clk_fall;
  logic w_data_sync;
  logic w_unused_data_fall;
  logic w_active;
  logic w_timeout;

  ps2_sync_edge u_sync_clk (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_line  (i_ps2clk),
    .o_sync  (w_clk_sync),
    .o_fall  (w_clk_fall)
  );

  ps2_sync_edge u_sync_data (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_line  (i_ps2data),
    .o_sync  (w_data_sync),
    .o_fall  (w_unused_data_fall)
  );

  // Timeout window covers everything from request-to-send until release.
  assign w_active  = r_state inside {ST_REQ, ST_SHIFT, ST_STOP, ST_ACK, ST_RELEASE};
  assign w_timeout = w_active && (r_to_cnt == TO_LIMIT);

  assign o_tx_ready = (r_state == ST_IDLE);
  assign o_busy     = (r_state != ST_IDLE);

  always_comb begin
    w_state_nxt   = r_state;
    o_ps2clk_low  = 1'b0;
    o_ps2data_low = 1'b0;
    o_done        = 1'b0;
    o_err         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_tx_valid) w_state_nxt = ST_INHIBIT;
      end
      ST_INHIBIT: begin
        o_ps2clk_low = 1'b1;
        // Data goes low on the last inhibit cycle so the start bit is
        // already present when the clock is released.
        if (r_inh_cnt == INH_LAST) begin
          o_ps2data_low = 1'b1;
          w_state_nxt   = ST_REQ;
        end
      end
      ST_REQ: begin
        o_ps2data_low = 1'b1;
        w_state_nxt   = ST_SHIFT;
      end
      ST_SHIFT: begin
        o_ps2data_low = r_data_low;
        if (w_clk_fall && (r_edge_cnt + 4'd1 == PARITY_EDGE)) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        // Parity stays on the line until edge 10 hands over to the stop bit.
        o_ps2data_low = r_data_low;
        if (w_clk_fall) w_state_nxt = ST_ACK;
      end
      ST_ACK: begin
        if (w_clk_fall) begin
          if (w_data_sync) begin
            o_err       = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        if (w_clk_sync && w_data_sync) begin
          o_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Timeout overrides whatever the state decided this cycle.
    if (w_timeout) begin
      o_ps2clk_low  = 1'b0;
      o_ps2data_low = 1'b0;
      o_done        = 1'b0;
      o_err         = 1'b1;
      w_state_nxt   = ST_IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_inh_cnt  <= '0;
      r_to_cnt   <= '0;
      r_edge_cnt <= '0;
      r_shift    <= '0;
      r_data_low <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          r_inh_cnt  <= '0;
          r_to_cnt   <= '0;
          r_edge_cnt <= '0;
          r_data_low <= 1'b0;
          if (i_tx_valid) r_shift <= {odd_parity(i_tx_data), i_tx_data};
        end
        ST_INHIBIT: begin
          if (r_inh_cnt != INH_LAST) r_inh_cnt <= r_inh_cnt + INH_W'(1);
        end
        ST_REQ: begin
          r_data_low <= 1'b1;
        end
        ST_SHIFT: begin
          if (w_clk_fall) begin
            r_data_low <= ~r_shift[0];
            r_shift    <= r_shift >> 1;
            r_edge_cnt <= r_edge_cnt + 4'd1;
          end
        end
        default: ;
      endcase
      if (w_active && (r_to_cnt != TO_LIMIT)) r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 CLK_FREQ_HZ, 100_000_000, system clock frequency, used to derive timing counts.
REQ-002 INHIBIT_US, 100, duration in microseconds that PS2CLK is held low before request-to-send.
REQ-003 TIMEOUT_MS, 20, maximum time in milliseconds from request-to-send to acknowledge before abort.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 tx_data  input  8  command byte to send to the keyboard (e.g. 0xED, 0xFF).
REQ-007 tx_valid  input  1  request to send tx_data; sampled only while tx_ready=1.
REQ-008 tx_ready  output  1  high only in IDLE.
REQ-009 PS2CLK  input  1  raw PS/2 clock line, asynchronous.
REQ-010 PS2Data  input  1  raw PS/2 data line, asynchronous.
REQ-011 ps2clk_low  output  1  1 = pull PS2CLK low (open-drain enable); 0 = release.
REQ-012 ps2data_low  output  1  1 = pull PS2Data low; 0 = release.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when the device has acknowledged and both lines are back high.
REQ-015 err  output  1  one-cycle pulse on missing acknowledge or timeout.

Function
REQ-016 PS2CLK and PS2Data SHALL each pass through a 2-flop synchronizer; a falling edge is synced-previous=1 and synced-current=0.
REQ-017 The FSM states SHALL be IDLE, INHIBIT, REQ, SHIFT, STOP, ACK, RELEASE.
REQ-018 IDLE: when tx_valid=1, latch tx_data, compute odd parity (parity = ~^tx_data), and go to INHIBIT on the next cycle.
REQ-019 INHIBIT: ps2clk_low=1 for exactly CLK_FREQ_HZ/1_000_000*INHIBIT_US cycles; ps2data_low=1 from the final cycle of INHIBIT onward.
REQ-020 REQ: ps2clk_low=0 and ps2data_low=1 (start bit); the timeout counter starts; go to SHIFT.
REQ-021 SHIFT: on each PS2CLK falling edge, drive the next bit (data bits LSB-first, then parity), with ps2data_low = ~bit; a 4-bit counter tracks edges 1..9; after edge 9 go to STOP.
REQ-022 STOP: on falling edge 10, release data (ps2data_low=0); go to ACK.
REQ-023 ACK: on falling edge 11, sample synced PS2Data; 0 = ack, go to RELEASE; 1 = pulse err and go to IDLE.
REQ-024 RELEASE: wait until synced PS2CLK=1 and PS2Data=1, then pulse done and go to IDLE.
REQ-025 Timeout: if REQ..RELEASE lasts longer than CLK_FREQ_HZ/1000*TIMEOUT_MS cycles, release both lines, pulse err, and go to IDLE; err takes priority over an edge arriving in the same cycle.
REQ-026 tx_valid is ignored while busy; tx_data is captured only at acceptance.
REQ-027 Counter widths SHALL be $clog2 of the maximum count, with no wrap before terminal count.
REQ-028 done and err SHALL never be asserted in the same cycle.

Reset
REQ-029 Reset SHALL force IDLE; tx_ready=1; busy=0; ps2clk_low=0; ps2data_low=0; done=0; err=0; all counters and synchronizer flops cleared to 1 (lines idle-high); reset mid-frame releases both lines on the next edge.

Structure
REQ-030 The state encoding, the parity function, and the PS/2 command constants (0xED set-LEDs, 0xFF reset, 0xF4 enable) SHALL live in the shared package ps2_pkg.
REQ-031 The edge detector and synchronizer SHALL be one sub-module, ps2_sync_edge, reusable by the existing receiver.

Verification
REQ-032 Send 0xED; device model clocks at 12.5 kHz and acks -> bits on lines: 1,0,1,1,0,1,1,1, parity=1, done pulses once, err=0.
REQ-033 Send 0x01 -> parity bit 0 observed at edge 9; done pulses.
REQ-034 Device model does not pull data low at edge 11 -> err pulses 1 cycle; both lines released; tx_ready=1.
REQ-035 Device model never clocks after REQ -> err exactly TIMEOUT_MS after REQ; lines released.
REQ-036 Assert reset at edge 5 of a frame -> the next cycle has ps2clk_low=0, ps2data_low=0, tx_ready=1; a following 0xFF send completes normally.
REQ-037 Measure INHIBIT with default parameters -> ps2clk_low held exactly 10_000 cycles; tx_valid pulses during busy do not alter the transmitted byte.
